alu_sequencer: RTL



---
 rtl/alu_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
// -----------------------------------------------------------------------------
// Register-file front end for a combinational WIDTH-bit ALU. It accepts one
// command at a time over a valid/ready handshake. It reads operand A from
// R[rd] and operand B from R[rs] or an immediate. It presents the operands and
// the control code to the ALU, writes the returned result into R[rd], and
// returns a result beat over a second valid/ready handshake.
//
// Each command runs as IDLE (accept) -> EXEC (ALU sample, R[rd] write) ->
// RESP (result beat held until res_ready).
//
// Optional feature macro: ALU_SEQ_STICKY_CARRY_EN
//   defined   : sticky_carry accumulates ADD/SUB carries. CLRF (1110) clears it
//               and returns 0 / carry 0 / zero 1.
//   undefined : sticky_carry is tied 0. CLRF is an ordinary unsupported code.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake
//   cmd_op            operation code
//   cmd_rd            destination register, also the operand A source
//   cmd_rs            operand B register
//   cmd_use_imm       1 selects cmd_imm as operand B
//   cmd_imm           immediate operand
//   alu_a/b/ctrl      operands and control code presented to the ALU
//   alu_out/carry/zero  ALU result, carry and zero flag
//   res_valid/ready   result handshake
//   res_data          result value
//   res_carry         result carry
//   res_zero          result zero flag
//   sticky_carry      accumulated carry (feature-dependent)
// -----------------------------------------------------------------------------
module alu_sequencer #(
   parameter int WIDTH = 6,
   parameter int NREG  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [1:0]       cmd_rd,
   input  logic [1:0]       cmd_rs,
   input  logic             cmd_use_imm,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_carry,
   output logic             res_zero,
   output logic             sticky_carry
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_CLRF = 4'b1110;
   localparam logic [3:0] OP_LOAD = 4'b1111;

   logic [1:0]       r_state;
   logic [3:0]       r_op;
   logic [1:0]       r_rd;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_ctrl;
   logic [WIDTH-1:0] r_regs [NREG];
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_carry;
   logic             r_res_zero;

   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_res_data;
   logic             w_res_carry;
   logic             w_res_zero;

   assign w_b = cmd_use_imm ? cmd_imm : r_regs[cmd_rs];

   // Result selection during EXEC. Codes 0000..1000 come from the ALU.
   // LOAD bypasses the ALU. CLRF and unsupported codes fall through to the
   // defaults: 0, carry 0, zero 1.
   always_comb begin
      w_res_data  = '0;
      w_res_carry = 1'b0;
      w_res_zero  = 1'b1;
      if (r_op == OP_LOAD) begin
         w_res_data = r_b;
         w_res_zero = (r_b == '0);
      end else if (r_op <= OP_SLT) begin
         w_res_data  = alu_out;
         w_res_carry = alu_carry;
         w_res_zero  = alu_zero;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_rd        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_ctrl      <= '0;
         r_res_data  <= '0;
         r_res_carry <= 1'b0;
         r_res_zero  <= 1'b0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  // Both operands are read here, before any write, so
                  // rd == rs sees the pre-operation value on A and B.
                  r_op    <= cmd_op;
                  r_rd    <= cmd_rd;
                  r_a     <= r_regs[cmd_rd];
                  r_b     <= w_b;
                  r_ctrl  <= (cmd_op == OP_LOAD) ? 4'b0000 : cmd_op;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_res_data   <= w_res_data;
               r_res_carry  <= w_res_carry;
               r_res_zero   <= w_res_zero;
               r_regs[r_rd] <= w_res_data;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (res_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_STICKY_CARRY_EN
   logic r_sticky;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (r_state == S_EXEC) begin
         if (r_op == OP_CLRF)
            r_sticky <= 1'b0;
         else if ((r_op == OP_ADD || r_op == OP_SUB) && alu_carry)
            r_sticky <= 1'b1;
      end
   end

   assign sticky_carry = r_sticky;
`else
   assign sticky_carry = 1'b0;
`endif

   // The operand latches drive the ALU directly. They hold outside EXEC,
   // which is harmless because the ALU is combinational.
   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_ctrl  = r_ctrl;
   assign cmd_ready = (r_state == S_IDLE);
   assign res_valid = (r_state == S_RESP);
   assign res_data  = r_res_data;
   assign res_carry = r_res_carry;
   assign res_zero  = r_res_zero;

endmodule
